// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the LED pattern generator.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE   = 2'd0,
    MODE_PINGPONG = 2'd1,
    MODE_FILL     = 2'd2,
    MODE_BLINK    = 2'd3
  } mode_e;

  // Width of the speed select; LIMIT = STEP_CYCLES >> speed.
  localparam int unsigned SPEED_W = 2;

  // Base step period in sys_clk cycles.
  function automatic int unsigned step_cycles_f(input int unsigned clk_freq,
                                                input int unsigned step_ms);
    return (clk_freq / 32'd1000) * step_ms;
  endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step timer: counts to a speed-scaled limit, freezes on pause, restarts on load.
module led_step_timer
  import led_pattern_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 25_000_000
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [SPEED_W-1:0] speed_i,
  input  logic               pause_i,
  input  logic               restart_i,
  output logic               tick_c
);

  localparam int unsigned TW = $clog2(STEP_CYCLES);

  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;
  int unsigned   limit_m1_c;

  // Compare with >= so a shortened limit fires immediately instead of wrapping.
  always_comb begin
    limit_m1_c = (STEP_CYCLES >> speed_i) - 32'd1;
    tick_c     = (32'(tcnt_q) >= limit_m1_c) && !pause_i;
    tcnt_d     = tcnt_q;
    if (restart_i || tick_c) begin
      tcnt_d = '0;
    end else if (!pause_i) begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

endmodule

// File: rtl/led_pattern.sv
// Active-low LED pattern generator: ROTATE, PINGPONG, FILL, BLINK.
// FILL is built only when LED_PATTERN_FILL_EN is defined; otherwise mode 2 runs ROTATE.
module led_pattern
  import led_pattern_pkg::*;
#(
  parameter int unsigned LED_NUM  = 8,
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned STEP_MS  = 500
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic               mode_vld,
  input  logic [SPEED_W-1:0] speed,
  input  logic               pause,
  output logic [LED_NUM-1:0] led_out,
  output logic               step_pulse
);

  localparam int unsigned STEP_CYCLES = step_cycles_f(CLK_FREQ, STEP_MS);
  localparam int unsigned PW          = $clog2(LED_NUM);
`ifdef LED_PATTERN_FILL_EN
  localparam int unsigned CW          = $clog2(LED_NUM + 1);
`endif

  mode_e              mode_q, mode_d, mode_load_c;
  logic [PW-1:0]      pos_q, pos_d;
  logic               dir_q, dir_d;      // 0 = up, 1 = down
  logic               phase_q, phase_d;
`ifdef LED_PATTERN_FILL_EN
  logic [CW-1:0]      cnt_q, cnt_d;
`endif
  logic [LED_NUM-1:0] led_q, led_d;
  logic [LED_NUM-1:0] lit_c;
  logic               pulse_q, pulse_d;
  logic               tick_c;

  led_step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_timer (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .speed_i   (speed),
    .pause_i   (pause),
    .restart_i (mode_vld),
    .tick_c    (tick_c)
  );

  // Map the requested mode onto the modes actually built.
  always_comb begin
`ifdef LED_PATTERN_FILL_EN
    mode_load_c = mode_e'(mode);
`else
    mode_load_c = (mode == 2'd2) ? MODE_ROTATE : mode_e'(mode);
`endif
  end

  // Pattern next-state: load restarts the mode and beats a coincident tick.
  always_comb begin
    mode_d  = mode_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    phase_d = phase_q;
`ifdef LED_PATTERN_FILL_EN
    cnt_d   = cnt_q;
`endif
    pulse_d = mode_vld | tick_c;

    if (mode_vld) begin
      mode_d  = mode_load_c;
      pos_d   = '0;
      dir_d   = 1'b0;
      phase_d = 1'b0;
`ifdef LED_PATTERN_FILL_EN
      cnt_d   = '0;
`endif
    end else if (tick_c) begin
      case (mode_q)
        MODE_PINGPONG: begin
          if (!dir_q) begin
            if (pos_q == PW'(LED_NUM - 1)) begin
              dir_d = 1'b1;
              pos_d = PW'(LED_NUM - 2);
            end else begin
              pos_d = pos_q + PW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = 1'b0;
              pos_d = PW'(1);
            end else begin
              pos_d = pos_q - PW'(1);
            end
          end
        end
`ifdef LED_PATTERN_FILL_EN
        MODE_FILL: begin
          cnt_d = (cnt_q == CW'(LED_NUM)) ? '0 : cnt_q + CW'(1);
        end
`endif
        MODE_BLINK: begin
          phase_d = ~phase_q;
        end
        default: begin
          pos_d = (pos_q == PW'(LED_NUM - 1)) ? '0 : pos_q + PW'(1);
        end
      endcase
    end
  end

  // Decode the next pattern state into lit positions, then drive active-low.
  always_comb begin
    lit_c = '0;
    case (mode_d)
      MODE_BLINK: begin
        lit_c = {LED_NUM{~phase_d}};
      end
`ifdef LED_PATTERN_FILL_EN
      MODE_FILL: begin
        for (int i = 0; i < int'(LED_NUM); i++) begin
          lit_c[i] = (CW'(i) < cnt_d);
        end
      end
`endif
      default: begin
        for (int i = 0; i < int'(LED_NUM); i++) begin
          lit_c[i] = (pos_d == PW'(i));
        end
      end
    endcase
    led_d = ~lit_c;
  end

  // State, LED and strobe registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      mode_q  <= MODE_ROTATE;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      phase_q <= 1'b0;
`ifdef LED_PATTERN_FILL_EN
      cnt_q   <= '0;
`endif
      led_q   <= {{(LED_NUM - 1){1'b1}}, 1'b0};
      pulse_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
`ifdef LED_PATTERN_FILL_EN
      cnt_q   <= cnt_d;
`endif
      led_q   <= led_d;
      pulse_q <= pulse_d;
    end
  end

  assign led_out    = led_q;
  assign step_pulse = pulse_q;

endmodule

// File: tb/tb_led_pattern.sv
// Directed bench for led_pattern with LED_NUM=8, STEP_CYCLES=10.
module tb_led_pattern;

  logic       sys_clk  = 1'b0;
  logic       rst_n    = 1'b0;
  logic [1:0] mode     = 2'd0;
  logic       mode_vld = 1'b0;
  logic [1:0] speed    = 2'd0;
  logic       pause    = 1'b0;
  logic [7:0] led_out;
  logic       step_pulse;

  int total = 0;
  int bad   = 0;

  led_pattern #(
    .LED_NUM  (8),
    .CLK_FREQ (1000),
    .STEP_MS  (10)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .mode_vld   (mode_vld),
    .speed      (speed),
    .pause      (pause),
    .led_out    (led_out),
    .step_pulse (step_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Cycles until the next step_pulse; 999 if none within 100 cycles.
  task automatic wait_step(output int n);
    n = 999;
    for (int i = 1; i <= 100; i++) begin
      @(negedge sys_clk);
      if (step_pulse === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic step_chk(input string tag, input int exp_n, input logic [7:0] exp_led);
    int n;
    wait_step(n);
    chk({tag, "_interval"}, n, exp_n);
    chk({tag, "_led"}, {24'd0, led_out}, {24'd0, exp_led});
  endtask

  task automatic load(input logic [1:0] m);
    mode     = m;
    mode_vld = 1'b1;
    @(negedge sys_clk);
    mode_vld = 1'b0;
  endtask

  function automatic logic [7:0] one_lit(input int p);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << p);
  endfunction

  function automatic logic [7:0] fill_led(input int c);
    logic [8:0] one;
    logic [8:0] m;
    one = 9'd1;
    m   = (one << c) - 9'd1;
    return ~m[7:0];
  endfunction

  initial begin
    int  pp [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    logic seen;
    logic moved;

    // Reset state
    idle(2);
    chk("reset_led", {24'd0, led_out}, 32'h0000_00FE);
    chk("reset_pulse", {31'd0, step_pulse}, 32'd0);
    rst_n = 1'b1;

    // ROTATE through wrap
    step_chk("rot1", 10, 8'hFD);
    for (int k = 2; k <= 8; k++) step_chk("rot", 10, one_lit(k % 8));

    // PINGPONG full period plus one step
    load(2'd1);
    chk("pp_load_led", {24'd0, led_out}, 32'h0000_00FE);
    chk("pp_load_pulse", {31'd0, step_pulse}, 32'd1);
    for (int k = 0; k < 15; k++) step_chk("pp", 10, one_lit(pp[k]));

    // FILL (or ROTATE when FILL is not built)
    load(2'd2);
`ifdef LED_PATTERN_FILL_EN
    chk("fill_load_led", {24'd0, led_out}, 32'h0000_00FF);
    for (int k = 1; k <= 9; k++) step_chk("fill", 10, fill_led(k % 9));
`else
    chk("fill_load_led", {24'd0, led_out}, 32'h0000_00FE);
    for (int k = 1; k <= 9; k++) step_chk("fill_rot", 10, one_lit(k % 8));
`endif

    // Speed change mid-count
    load(2'd0);
    chk("spd_load_led", {24'd0, led_out}, 32'h0000_00FE);
    idle(7);
    speed = 2'd2;
    step_chk("spd2_first", 1, 8'hFD);
    step_chk("spd2_a", 2, 8'hFB);
    step_chk("spd2_b", 2, 8'hF7);
    speed = 2'd3;
    step_chk("spd3_a", 1, 8'hEF);
    step_chk("spd3_b", 1, 8'hDF);

    // Pause at tcnt=4 for 50 cycles
    speed = 2'd0;
    idle(4);
    pause = 1'b1;
    seen  = 1'b0;
    moved = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge sys_clk);
      if (step_pulse !== 1'b0) seen = 1'b1;
      if (led_out !== 8'hDF) moved = 1'b1;
    end
    chk("pause_no_pulse", {31'd0, seen}, 32'd0);
    chk("pause_led_held", {31'd0, moved}, 32'd0);
    pause = 1'b0;
    step_chk("pause_resume", 6, 8'hBF);

    // Load coincident with tick
    idle(9);
    load(2'd3);
    chk("blink_load_led", {24'd0, led_out}, 32'h0000_0000);
    chk("blink_load_pulse", {31'd0, step_pulse}, 32'd1);
    step_chk("blink1", 10, 8'hFF);
    step_chk("blink2", 10, 8'h00);

    // Load while paused
    pause = 1'b1;
    load(2'd1);
    chk("pload_led", {24'd0, led_out}, 32'h0000_00FE);
    chk("pload_pulse", {31'd0, step_pulse}, 32'd1);
    idle(20);
    chk("pload_hold_led", {24'd0, led_out}, 32'h0000_00FE);
    chk("pload_hold_pulse", {31'd0, step_pulse}, 32'd0);
    pause = 1'b0;
    step_chk("pload_resume", 10, 8'hFD);

    // Reset mid-run
    idle(3);
    rst_n = 1'b0;
    @(negedge sys_clk);
    chk("rst_mid_led", {24'd0, led_out}, 32'h0000_00FE);
    chk("rst_mid_pulse", {31'd0, step_pulse}, 32'd0);
    rst_n = 1'b1;
    step_chk("rst_after", 10, 8'hFD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern.md
# led_pattern

Parametrised active-low LED pattern generator: N LEDs, four run-time-selectable patterns, selectable step rate and pause. It sits between board-level control logic (keys, UART command decoder) and the LED pins, replacing the fixed 8-LED ping-pong runner. All state is advanced by a single internal step timer derived from `CLK_FREQ`.

## Interface
- `LED_NUM`, 8, number of LEDs; legal range 2..32.
- `CLK_FREQ`, 50_000_000, sys_clk frequency in Hz.
- `STEP_MS`, 500, base step period in ms; `STEP_CYCLES = CLK_FREQ/1000*STEP_MS`, must be >= 8.
- `sys_clk`  in  1  clock, all logic rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `mode`  in  2  pattern select, sampled only when `mode_vld`=1.
- `mode_vld`  in  1  single-cycle load strobe for `mode`.
- `speed`  in  2  rate select, continuously sampled; step limit `LIMIT = STEP_CYCLES >> speed`.
- `pause`  in  1  level; 1 freezes timer and pattern.
- `led_out`  out  LED_NUM  LED drive, active-low (0 = lit), registered.
- `step_pulse`  out  1  one-cycle strobe, high in the cycle after every `led_out` step or mode load.

## Operation
- Modes (lit-position view, then inverted onto `led_out`):
  - 0 ROTATE: single lit LED at `pos`, pos 0→1→…→N-1→0.
  - 1 PINGPONG: pos 0→N-1 then N-2→0, direction flips at ends, endpoints never repeated; period 2(N-1) steps.
  - 2 FILL: `cnt` 0→N then wraps to 0; lit LEDs = bits [cnt-1:0]; N+1 states.
  - 3 BLINK: `phase` toggles; phase 0 = all lit, phase 1 = all dark.
- Initial state of each mode (after reset or load): ROTATE/PINGPONG pos=0, dir=up (`led_out`=~1, 8'hFE for N=8); FILL cnt=0 (all 1s); BLINK phase=0 (all 0s).
- Reset values: mode=ROTATE, pos=0, dir=up, cnt=0, phase=0, timer=0, `led_out`=~1, `step_pulse`=0.
- Step timer: counter `tcnt` width `$clog2(STEP_CYCLES)`; `tick` = (`tcnt` >= LIMIT-1) && !pause; on tick `tcnt`←0, else if !pause `tcnt`+1, else hold.
- `>=` compare: lowering LIMIT mid-count (speed increase) produces a tick on the next unpaused cycle, never a counter wrap.
- On tick: pattern state advances one step; `led_out` takes the new pattern on the same edge.
- Mode load (`mode_vld`=1): at that edge mode←`mode`, pattern state←initial state of new mode, `tcnt`←0, `led_out`←initial pattern. Reloading the current mode also restarts it. Load has priority over a coincident tick.
- Load while `pause`=1: loaded and displayed, remains frozen until pause drops.
- Pause: `led_out` and `tcnt` hold; on release, remaining count resumes (no restart).
- `rst_n`=0 mid-operation: all state returns to reset values at that edge regardless of other inputs.

## Timing
- Step interval: exactly LIMIT cycles between `led_out` changes when unpaused and speed constant.
- Load latency: `led_out` shows new mode's initial pattern the cycle after `mode_vld`; first step follows LIMIT cycles later.
- `step_pulse`: registered, high exactly one cycle, the cycle after each tick edge or load edge; never high during pause except following a load.

## Configuration
- `LED_PATTERN_FILL_EN` defined: mode 2 is FILL as above.
- Undefined: FILL logic and `cnt` register are not built; mode 2 decodes as ROTATE (identical sequence and initial state).

## Structure
- `led_pattern_pkg`: mode enum (ROTATE=0, PINGPONG=1, FILL=2, BLINK=3), speed shift-width constant, `STEP_CYCLES` computation function.
- Sub-module `led_step_timer`: owns `tcnt`, LIMIT shift, pause and restart; outputs `tick`. Pattern registers and decode stay in `led_pattern`.

## Test plan
Bench parameters: LED_NUM=8, CLK_FREQ=1000, STEP_MS=10 (STEP_CYCLES=10).
- Reset, speed=0 -> `led_out`=8'hFE, `step_pulse`=0; after 10 cycles 8'hFD; 8'h7F → 8'hFE wrap in ROTATE.
- Load PINGPONG -> FE,FD,FB,…,7F,BF,DF,…,FE; 7F followed directly by BF, FE by FD; 14-step period.
- Load FILL -> FF,FE,FC,F8,…,80,00,FF; with macro undefined, mode 2 gives ROTATE sequence.
- speed=0, at `tcnt`=7 switch speed=2 (LIMIT=2) -> step on next cycle, then every 2 cycles; speed=3 -> step every cycle.
- pause high 50 cycles at `tcnt`=4 -> `led_out` frozen, no `step_pulse`; after release step occurs 6 cycles later.
- `mode_vld` coincident with tick, mode=BLINK -> `led_out`=8'h00 next cycle (no advance), `step_pulse` once, then 8'hFF after 10 cycles; `rst_n` pulse mid-run -> 8'hFE.
